whr_sw_alloc_lock: RTL

Wormhole switch allocator for the wormhole router: arbitrates input-port flit requests onto output ports and holds each output locked to one input from head flit to tail flit. Sits between the input controllers (route/request/head/tail per input) and the crossbar plus output controllers (crossbar select, valid/head/tail per output). It replaces the generic allocator with a per-output lock-and-round-robin scheme and adds protocol checking.

---
 rtl/whr_sw_alloc_lock_pkg.sv | 24 ++
 rtl/whr_sw_alloc_lock_op.sv | 109 ++++++++++
 rtl/whr_sw_alloc_lock.sv | 81 ++++++++
 3 files changed

// File: rtl/whr_sw_alloc_lock_pkg.sv
// Shared types and helpers for the wormhole switch allocator with per-output locking.
// Holds the output lock state encoding and the clogb width helper.
package whr_sw_alloc_lock_pkg;

    localparam int NUM_PORTS = 5;

    typedef enum logic {
        OP_IDLE   = 1'b0,
        OP_LOCKED = 1'b1
    } op_state_e;

    // Bits needed to encode 0..value-1; never less than 1.
    function automatic int clogb(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/whr_sw_alloc_lock_op.sv
// Per-output arbiter: round-robin among head flits while idle, then held by one
// input from head to tail. Also raises this output's protocol-violation terms.
module whr_sw_alloc_lock_op
    import whr_sw_alloc_lock_pkg::*;
#(
    parameter int num_ports = NUM_PORTS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [num_ports-1:0] req,
    input  logic [num_ports-1:0] req_head,
    input  logic [num_ports-1:0] req_tail,
    input  logic [num_ports-1:0] route,
    input  logic                 full,
    output logic [num_ports-1:0] grant,
    output logic                 flit_valid,
    output logic                 flit_head,
    output logic                 flit_tail,
    output logic                 err
);

    localparam int ptr_w = clogb(num_ports);

    op_state_e          state_q, state_d;
    logic [ptr_w-1:0]   owner_q, owner_d;
    logic [ptr_w-1:0]   ptr_q, ptr_d;
    logic [ptr_w-1:0]   winner;
    logic [ptr_w-1:0]   idx;
    logic               found;
    logic [num_ports-1:0] routed;
    logic [num_ports-1:0] elig;

    assign routed = req & route;
    assign elig   = routed & {num_ports{~full}};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= OP_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        winner     = '0;
        idx        = '0;
        found      = 1'b0;
        grant      = '0;
        case (state_q)
            OP_IDLE: begin
                // First eligible head flit at or after the pointer, wrapping.
                for (int k = 0; k < num_ports; k++) begin
                    idx = ptr_w'((int'(ptr_q) + k) % num_ports);
                    if (!found && elig[idx] && req_head[idx]) begin
                        found  = 1'b1;
                        winner = idx;
                    end
                end
                if (found) begin
                    ptr_d = (winner == ptr_w'(num_ports - 1)) ? '0 : winner + 1'b1;
                    if (!req_tail[winner]) begin
                        state_d = OP_LOCKED;
                        owner_d = winner;
                    end
                end
            end
            OP_LOCKED: begin
                if (elig[owner_q]) begin
                    found  = 1'b1;
                    winner = owner_q;
                    if (req_tail[owner_q]) begin
                        state_d = OP_IDLE;
                    end
                end
            end
            default: state_d = OP_IDLE;
        endcase
        if (found) begin
            grant[winner] = 1'b1;
        end
        flit_valid = found;
        flit_head  = found & req_head[winner];
        flit_tail  = found & req_tail[winner];
    end

    // Violations are judged on any routed request, whether or not credit exists.
    always_comb begin
        err = 1'b0;
        for (int ip = 0; ip < num_ports; ip++) begin
            if (routed[ip]) begin
                if (state_q == OP_IDLE) begin
                    if (!req_head[ip]) err = 1'b1;
                end else if (ptr_w'(ip) == owner_q) begin
                    if (req_head[ip]) err = 1'b1;
                end else if (!req_head[ip]) begin
                    err = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/whr_sw_alloc_lock.sv
// Wormhole switch allocator top: one locking arbiter per output, crossbar select
// and grant fan-in, plus a registered protocol-error pulse.
module whr_sw_alloc_lock
    import whr_sw_alloc_lock_pkg::*;
#(
    parameter int num_ports = NUM_PORTS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [num_ports*num_ports-1:0] route_ip_op,
    input  logic [num_ports-1:0]           req_ip,
    input  logic [num_ports-1:0]           req_head_ip,
    input  logic [num_ports-1:0]           req_tail_ip,
    input  logic [num_ports-1:0]           full_op,
    output logic [num_ports-1:0]           gnt_ip,
    output logic [num_ports-1:0]           flit_valid_op,
    output logic [num_ports-1:0]           flit_head_op,
    output logic [num_ports-1:0]           flit_tail_op,
    output logic [num_ports*num_ports-1:0] xbr_ctrl_op_ip,
    output logic                           error
);

    logic [num_ports-1:0] grant_op_ip [num_ports];
    logic [num_ports-1:0] err_op;
    logic [num_ports-1:0] route_err_ip;
    logic                 error_d;

    for (genvar op = 0; op < num_ports; op++) begin : g_op
        logic [num_ports-1:0] route_col;

        // route_ip_op is input-major; gather this output's column.
        always_comb begin
            route_col = '0;
            for (int ip = 0; ip < num_ports; ip++) begin
                route_col[ip] = route_ip_op[ip*num_ports + op];
            end
        end

        whr_sw_alloc_lock_op #(.num_ports(num_ports)) u_op (
            .clk        (clk),
            .reset      (reset),
            .req        (req_ip),
            .req_head   (req_head_ip),
            .req_tail   (req_tail_ip),
            .route      (route_col),
            .full       (full_op[op]),
            .grant      (grant_op_ip[op]),
            .flit_valid (flit_valid_op[op]),
            .flit_head  (flit_head_op[op]),
            .flit_tail  (flit_tail_op[op]),
            .err        (err_op[op])
        );

        assign xbr_ctrl_op_ip[op*num_ports +: num_ports] = grant_op_ip[op];
    end

    always_comb begin
        gnt_ip = '0;
        for (int op = 0; op < num_ports; op++) begin
            gnt_ip = gnt_ip | grant_op_ip[op];
        end
    end

    always_comb begin
        route_err_ip = '0;
        for (int ip = 0; ip < num_ports; ip++) begin
            route_err_ip[ip] = req_ip[ip] & ~$onehot(route_ip_op[ip*num_ports +: num_ports]);
        end
    end

    assign error_d = (|err_op) | (|route_err_ip);

    always_ff @(posedge clk) begin
        if (reset) begin
            error <= 1'b0;
        end else begin
            error <= error_d;
        end
    end

endmodule
